dq_ctrl: RTL
============

Name: dq_ctrl

Overview:
- Parametrised delay-queue successor to the plain fixed-depth shift delay used across the FPU datapath.
- Delays a WIDTH-bit payload plus a valid bit through up to DEPTH register stages.
- Adds a pipeline-advance enable (stall), synchronous flush, and a runtime-selectable tap so one instance serves variable-latency FPU ops.
- Adds in-flight status outputs so the issue logic can tell when the queue has drained.

Parameters:
- WIDTH, 8, payload width in bits (>=1).
- DEPTH, 2, maximum number of delay stages (>=1).
- LW, $clog2(DEPTH+1), width of the len and count ports (derived; do not override).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- en  input  1  advance enable; 0 = stall, all stages hold.
- flush  input  1  synchronous clear of all valid bits.
- len  input  LW  selected delay in stages; effective range 1..DEPTH.
- in_valid  input  1  payload d is valid.
- d  input  WIDTH  payload in.
- out_valid  output  1  valid bit at the selected tap.
- q  output  WIDTH  payload at the selected tap.
- busy  output  1  any valid item in stages 0..L-1.
- count  output  LW  number of valid items in stages 0..L-1.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Storage: data[0..DEPTH-1] (WIDTH bits each), vld[0..DEPTH-1].
- Effective length L:
  - L = 1 if len==0.
  - L = DEPTH if len>DEPTH.
  - else L = len.
- Priority at each rising edge: rst > flush > en.
- rst=1: all vld<=0, all data<=0. Outputs next cycle: out_valid=0, q=0, busy=0, count=0. Reset mid-stream discards everything in flight.
- flush=1 (rst=0):
  - All vld<=0, regardless of en or in_valid; the item presented that cycle is dropped.
  - data registers are not required to change.
- en=1 (rst=0, flush=0):
  - data[0]<=d, vld[0]<=in_valid.
  - data[i]<=data[i-1], vld[i]<=vld[i-1] for i=1..DEPTH-1.
  - Data shifts even when invalid.
- en=0: every stage holds; in_valid/d ignored (caller must keep them stable or accept loss).
- Outputs are combinational from registers only; no input-to-output combinational path except through len mux select:
  - q=data[L-1], out_valid=vld[L-1].
  - busy = OR vld[0..L-1].
  - count = popcount vld[0..L-1].
- Latency: an item accepted with en=1 at edge k appears at q/out_valid after edge k+L-1 when en stays 1, i.e. L edges including the capture edge. Each stall cycle adds one cycle.
- Stall with item at tap: out_valid and q stay asserted unchanged for every en=0 cycle. The consumer treats an item as taken only on cycles with en=1.
- len change while items in flight:
  - Takes effect immediately on the mux.
  - Increasing L re-exposes older stages, whose vld may be 1.
  - Decreasing L: items in stages >= new L are no longer visible and fall off.
  - The caller changes len only when busy=0; the block does not protect against misuse.
- Simultaneous flush and in_valid: flush wins, queue empty next cycle.
- DEPTH=1: L is always 1; block is a single enabled register with valid.
- No X on outputs after the first reset edge.

Test Plan:
1. Reset: DEPTH=4, WIDTH=8. Hold rst 2 cycles with in_valid=1, d=8'hAA. Required: out_valid=0, q=0, busy=0, count=0 the cycle after.
2. Latency: len=3, en=1. Single in_valid pulse with d=8'h5C at edge k. Required: out_valid=1, q=8'h5C only in the cycle after edge k+2; count goes 1,1,1 then 0.
3. Stall: len=2. Stream d=1,2,3 valid. Deassert en for 3 cycles while d=1 is at the tap. Required: q=1, out_valid=1 held 3 cycles, then order 1,2,3 intact with no duplicates or losses.
4. Flush: len=4, 3 valid items in flight. Assert flush with en=1, in_valid=1, d=8'hFF. Required next cycle: busy=0, count=0, out_valid=0 for the following 4 cycles.
5. Clamping: DEPTH=4.
   - len=0: latency 1.
   - len=7: latency 4, identical to len=4.
   - Check with d=8'h11.
6. Back-to-back random: 1000 cycles of random en/in_valid/d, len=DEPTH, no flush. Scoreboard: output sequence equals input sequence; count equals the scoreboard occupancy each cycle.

Source files
------------

// File: rtl/dq_ctrl_if.sv
// dq_ctrl_if: control, payload and status bundle of the delay queue.
// master drives the queue inputs, slave is the queue itself.
interface dq_ctrl_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
);
  logic             en;
  logic             flush;
  logic [LW-1:0]    len;
  logic             in_valid;
  logic [WIDTH-1:0] d;
  logic             out_valid;
  logic [WIDTH-1:0] q;
  logic             busy;
  logic [LW-1:0]    count;

  modport master (
    output en, flush, len, in_valid, d,
    input  out_valid, q, busy, count
  );

  modport slave (
    input  en, flush, len, in_valid, d,
    output out_valid, q, busy, count
  );
endinterface

// File: rtl/dq_ctrl.sv
// dq_ctrl: variable-tap delay queue with stall, flush and in-flight status.
// Payload and valid shift together; len selects which stage is visible.
module dq_ctrl #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  parameter int LW    = $clog2(DEPTH + 1)
) (
  input logic     clk,
  input logic     rst,
  dq_ctrl_if.slave bus
);

  logic [DEPTH-1:0][WIDTH-1:0] data_q, data_d;
  logic [DEPTH-1:0]            vld_q, vld_d;

  logic [LW-1:0]    l_eff;
  logic [LW-1:0]    tap;
  logic [WIDTH-1:0] q_sel;
  logic             ov_sel;
  logic [LW-1:0]    cnt;

  always_comb begin
    data_d = data_q;
    vld_d  = vld_q;
    if (bus.flush) begin
      vld_d = '0;
    end else if (bus.en) begin
      data_d[0] = bus.d;
      vld_d[0]  = bus.in_valid;
      for (int i = 1; i < DEPTH; i++) begin
        data_d[i] = data_q[i-1];
        vld_d[i]  = vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
      vld_q  <= '0;
    end else begin
      data_q <= data_d;
      vld_q  <= vld_d;
    end
  end

  // Out-of-range len clamps into 1..DEPTH.
  always_comb begin
    if (bus.len == '0) begin
      l_eff = LW'(1);
    end else if (bus.len > LW'(DEPTH)) begin
      l_eff = LW'(DEPTH);
    end else begin
      l_eff = bus.len;
    end
  end

  always_comb begin
    tap    = l_eff - LW'(1);
    q_sel  = '0;
    ov_sel = 1'b0;
    cnt    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (LW'(i) == tap) begin
        q_sel  = data_q[i];
        ov_sel = vld_q[i];
      end
      if ((LW'(i) < l_eff) && vld_q[i]) begin
        cnt = cnt + LW'(1);
      end
    end
  end

  assign bus.q         = q_sel;
  assign bus.out_valid = ov_sel;
  assign bus.count     = cnt;
  assign bus.busy      = (cnt != '0);

endmodule
